// File: rtl/retire_trace_pkg.sv
// retire_trace_pkg
// Shared widths, lane/group record types and a lane-select helper for the
// retire trace writer.
//   RET_LANES : number of backend retire lanes
//   RT_W      : destination register index width
//   DATA_W    : per-lane result data width
//   SEQ_W     : trace record sequence number width
//   LANE_W    : width of a lane index (0..RET_LANES-1)
package retire_trace_pkg;

  localparam int RET_LANES = 9;
  localparam int RT_W      = 6;
  localparam int DATA_W    = 65;
  localparam int SEQ_W     = 16;
  localparam int LANE_W    = 4;

  // One retired lane as it appears in a trace record.
  typedef struct packed {
    logic [RT_W-1:0]   rT;
    logic [DATA_W-1:0] data;
  } lane_rec_t;

  // A whole retire group: the lanes that actually retired plus every lane payload.
  typedef struct packed {
    logic [RET_LANES-1:0]                mask;
    lane_rec_t [RET_LANES-1:0]           lanes;
  } ret_grp_t;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [LANE_W-1:0] lowestLane(input logic [RET_LANES-1:0] m);
    lowestLane = '0;
    for (int i = RET_LANES - 1; i >= 0; i--) begin
      if (m[i]) lowestLane = LANE_W'(i);
    end
  endfunction

endpackage

// File: rtl/retire_trace_writer_if.sv
// retire_trace_writer_if
// Bundles the backend retire group inputs, the serialized trace record
// outputs and the sticky status flags.
//   master : the backend/consumer side (drives retire group and out_ready)
//   slave  : the trace writer itself
interface retire_trace_writer_if;
  import retire_trace_pkg::*;

  logic                             retM_retire;
  logic [RET_LANES-1:0]             retM_xbreak;
  logic [RET_LANES-1:0]             ret_en;
  logic [RET_LANES-1:0][RT_W-1:0]   ret_rT;
  logic [RET_LANES-1:0][DATA_W-1:0] ret_data;
  logic                             retire_stall;

  logic                             out_valid;
  logic                             out_ready;
  logic [RT_W-1:0]                  out_rT;
  logic [DATA_W-1:0]                out_data;
  logic [LANE_W-1:0]                out_lane;
  logic                             out_last;
  logic [SEQ_W-1:0]                 out_seq;

  logic                             overflow;
  logic                             hang;

  modport master (
    output retM_retire, retM_xbreak, ret_en, ret_rT, ret_data, out_ready,
    input  retire_stall, out_valid, out_rT, out_data, out_lane, out_last,
           out_seq, overflow, hang
  );

  modport slave (
    input  retM_retire, retM_xbreak, ret_en, ret_rT, ret_data, out_ready,
    output retire_stall, out_valid, out_rT, out_data, out_lane, out_last,
           out_seq, overflow, hang
  );

endinterface

// File: rtl/retire_grp_fifo.sv
// retire_grp_fifo
// DEPTH-entry FIFO of whole retire groups.
//   clk, rst : clock, synchronous active-high reset (clears pointers only)
//   i_push   : write i_data when not full
//   i_pop    : advance the head when not empty
//   o_head   : current head group (meaningless while o_empty)
//   o_full   : no free entry; a push is ignored even if a pop happens this cycle
//   o_empty  : no entry held
module retire_grp_fifo
  import retire_trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_push,
  input  ret_grp_t i_data,
  input  logic     i_pop,
  output ret_grp_t o_head,
  output logic     o_full,
  output logic     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0] r_wptr;
  logic [PTR_W:0] r_rptr;
  ret_grp_t       r_mem [DEPTH];

  // The extra top pointer bit tells a wrapped-full FIFO apart from an empty one.
  assign o_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                   (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign o_empty = (r_wptr == r_rptr);
  assign o_head  = r_mem[r_rptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push && !o_full)  r_wptr <= r_wptr + (PTR_W+1)'(1);
      if (i_pop  && !o_empty) r_rptr <= r_rptr + (PTR_W+1)'(1);
    end
  end

  // Storage is not reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (i_push && !o_full) r_mem[r_wptr[PTR_W-1:0]] <= i_data;
  end

endmodule

// File: rtl/retire_trace_writer.sv
// retire_trace_writer
// Captures each cycle's retire group into a small group FIFO and serializes
// it into one trace record per retired lane, lowest lane first.
//   clk, rst : clock, synchronous active-high reset
//   bus      : retire_trace_writer_if.slave
//              in : retM_retire, retM_xbreak, ret_en, ret_rT, ret_data, out_ready
//              out: retire_stall, out_valid, out_rT, out_data, out_lane,
//                   out_last, out_seq, overflow, hang
//   DEPTH      : group FIFO entries (power of 2, >= 2)
//   HANG_LIMIT : consecutive no-push cycles that raise hang
module retire_trace_writer
  import retire_trace_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int HANG_LIMIT = 2000
) (
  input logic                  clk,
  input logic                  rst,
  retire_trace_writer_if.slave bus
);

  localparam int CNT_W = $clog2(HANG_LIMIT + 1);

  logic [RET_LANES-1:0] w_mask;
  logic                 w_push;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_valid;
  logic                 w_accept;
  logic                 w_last;
  logic [RET_LANES-1:0] w_curMask;
  logic [RET_LANES-1:0] w_remNext;
  logic [LANE_W-1:0]    w_lane;
  lane_rec_t            w_rec;
  ret_grp_t             w_grpIn;
  ret_grp_t             w_head;
  logic [CNT_W-1:0]     w_hangNext;

  logic [RET_LANES-1:0] r_remMask;
  logic [SEQ_W-1:0]     r_seq;
  logic [CNT_W-1:0]     r_hangCnt;
  logic                 r_overflow;
  logic                 r_hang;

  assign w_mask = bus.ret_en & ~bus.retM_xbreak & {RET_LANES{bus.retM_retire}};
  assign w_push = (|w_mask) & ~w_full;

  always_comb begin
    w_grpIn      = '0;
    w_grpIn.mask = w_mask;
    for (int i = 0; i < RET_LANES; i++) begin
      w_grpIn.lanes[i].rT   = bus.ret_rT[i];
      w_grpIn.lanes[i].data = bus.ret_data[i];
    end
  end

  retire_grp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_grpIn),
    .i_pop   (w_accept & w_last),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A zero remaining mask means the head group has not been started yet, so
  // its full mask is used directly; this is what lets a new group follow the
  // previous one's last record with no bubble.
  assign w_curMask = (r_remMask != '0) ? r_remMask : w_head.mask;
  assign w_lane    = lowestLane(w_curMask);
  assign w_rec     = w_head.lanes[w_lane];
  assign w_remNext = w_curMask & (w_curMask - RET_LANES'(1));
  assign w_last    = (w_remNext == '0);
  assign w_valid   = ~w_empty & ~rst;
  assign w_accept  = w_valid & bus.out_ready;

  // Serializer progress and record sequence number.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_remMask <= '0;
      r_seq     <= '0;
    end else if (w_accept) begin
      r_seq     <= r_seq + SEQ_W'(1);
      r_remMask <= w_last ? '0 : w_remNext;
    end
  end

  // Watchdog and drop detection; both flags stay set until reset.
  assign w_hangNext = w_push ? '0 :
                      (r_hangCnt == CNT_W'(HANG_LIMIT)) ? r_hangCnt :
                      r_hangCnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hangCnt  <= '0;
      r_hang     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_hangCnt <= w_hangNext;
      if (w_hangNext == CNT_W'(HANG_LIMIT)) r_hang <= 1'b1;
      if ((|w_mask) && w_full)              r_overflow <= 1'b1;
    end
  end

  assign bus.retire_stall = w_full & ~rst;
  assign bus.out_valid    = w_valid;
  assign bus.out_rT       = w_valid ? w_rec.rT   : '0;
  assign bus.out_data     = w_valid ? w_rec.data : '0;
  assign bus.out_lane     = w_valid ? w_lane     : '0;
  assign bus.out_last     = w_valid & w_last;
  assign bus.out_seq      = r_seq;
  assign bus.overflow     = r_overflow;
  assign bus.hang         = r_hang;

endmodule

// File: tb/tb_retire_trace_writer.sv
// tb_retire_trace_writer
// Random and directed retire groups are fed to retire_trace_writer. A
// reference model at each rising edge turns every accepted group into its
// expected records on a scoreboard queue; a monitor on the falling edge pops
// and compares whenever a record is handed over.
module tb_retire_trace_writer;
  import retire_trace_pkg::*;

  localparam int DEPTH      = 4;
  localparam int HANG_LIMIT = 2000;

  typedef struct {
    logic [RT_W-1:0]   rT;
    logic [DATA_W-1:0] data;
    logic [LANE_W-1:0] lane;
    logic              last;
  } exp_rec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  retire_trace_writer_if bus ();

  retire_trace_writer #(.DEPTH(DEPTH), .HANG_LIMIT(HANG_LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_rec_t expQ[$];
  int       grpQ[$];
  int       nAssert = 0;
  int       nFail   = 0;
  int       acceptedTotal = 0;
  logic [SEQ_W-1:0] expSeq = '0;
  logic     mOverflow = 1'b0;
  logic     mHang = 1'b0;
  int       mHangCnt = 0;

  // Model scratch
  logic [RET_LANES-1:0] mMask;
  bit       mFull;
  int       mCnt;
  int       mIdx;
  exp_rec_t mRec;

  // Monitor scratch
  exp_rec_t eRec;
  bit       holdPrev = 0;
  logic [95:0] prevFields;

  task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic retire, input logic [RET_LANES-1:0] en,
                               input logic [RET_LANES-1:0] xbreak, input logic ready);
    bus.retM_retire = retire;
    bus.ret_en      = en;
    bus.retM_xbreak = xbreak;
    bus.out_ready   = ready;
    for (int i = 0; i < RET_LANES; i++) begin
      bus.ret_rT[i]   = RT_W'($urandom);
      bus.ret_data[i] = DATA_W'({$urandom, $urandom, $urandom});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0);
    rst = 1'b0;
  endtask

  // Reference model: a queue of groups, each just a count of records still
  // owed, plus the expected record stream.
  always @(posedge clk) begin
    if (rst) begin
      expQ.delete();
      grpQ.delete();
      mOverflow = 1'b0;
      mHang     = 1'b0;
      mHangCnt  = 0;
    end else begin
      mFull = (grpQ.size() == DEPTH);
      if (grpQ.size() > 0 && bus.out_ready) begin
        grpQ[0] = grpQ[0] - 1;
        if (grpQ[0] == 0) void'(grpQ.pop_front());
      end
      mMask = bus.ret_en & ~bus.retM_xbreak & {RET_LANES{bus.retM_retire}};
      if (mMask != '0 && !mFull) begin
        mCnt = $countones(mMask);
        mIdx = 0;
        for (int i = 0; i < RET_LANES; i++) begin
          if (mMask[i]) begin
            mIdx++;
            mRec.rT   = bus.ret_rT[i];
            mRec.data = bus.ret_data[i];
            mRec.lane = LANE_W'(i);
            mRec.last = (mIdx == mCnt);
            expQ.push_back(mRec);
          end
        end
        grpQ.push_back(mCnt);
        mHangCnt = 0;
      end else begin
        if (mMask != '0) mOverflow = 1'b1;
        if (mHangCnt < HANG_LIMIT) mHangCnt++;
      end
      if (mHangCnt == HANG_LIMIT) mHang = 1'b1;
    end
  end

  // Monitor: compares every presented record and the status outputs.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rst_valid", 96'(bus.out_valid), 96'(0));
      checkOutput("rst_stall", 96'(bus.retire_stall), 96'(0));
      checkOutput("rst_fields", {bus.out_rT, bus.out_data, bus.out_lane, bus.out_last}, 96'(0));
      expSeq        = '0;
      acceptedTotal = 0;
      holdPrev      = 0;
    end else begin
      checkOutput("out_valid", 96'(bus.out_valid), 96'(expQ.size() != 0));
      checkOutput("retire_stall", 96'(bus.retire_stall), 96'(grpQ.size() == DEPTH));
      checkOutput("overflow", 96'(bus.overflow), 96'(mOverflow));
      checkOutput("hang", 96'(bus.hang), 96'(mHang));
      if (holdPrev)
        checkOutput("stable_while_stalled",
                    {bus.out_rT, bus.out_data, bus.out_lane, bus.out_last, bus.out_seq},
                    prevFields);
      if (bus.out_valid && expQ.size() > 0) begin
        eRec = expQ[0];
        checkOutput("rec_rT", 96'(bus.out_rT), 96'(eRec.rT));
        checkOutput("rec_data", 96'(bus.out_data), 96'(eRec.data));
        checkOutput("rec_lane", 96'(bus.out_lane), 96'(eRec.lane));
        checkOutput("rec_last", 96'(bus.out_last), 96'(eRec.last));
        checkOutput("rec_seq", 96'(bus.out_seq), 96'(expSeq));
        if (bus.out_ready) begin
          void'(expQ.pop_front());
          expSeq = expSeq + SEQ_W'(1);
          acceptedTotal++;
        end
      end
      holdPrev   = bus.out_valid && !bus.out_ready;
      prevFields = {bus.out_rT, bus.out_data, bus.out_lane, bus.out_last, bus.out_seq};
    end
  end

  initial begin
    int lanes8[8];
    bit reached;
    lanes8 = '{0, 1, 2, 3, 5, 6, 7, 8};
    rst = 1'b1;
    bus.retM_retire = 1'b0;
    bus.ret_en      = '0;
    bus.retM_xbreak = '0;
    bus.out_ready   = 1'b0;
    bus.ret_rT      = '0;
    bus.ret_data    = '0;
    doReset();

    // Three-lane group: lanes 0, 2, 8 on consecutive cycles, seq 0..2.
    applyStimulus(1'b1, 9'h105, 9'h000, 1'b1);
    checkOutput("g105_rec0", {bus.out_valid, bus.out_lane, bus.out_last, bus.out_seq},
                {1'b1, 4'd0, 1'b0, 16'd0});
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("g105_rec1", {bus.out_valid, bus.out_lane, bus.out_last, bus.out_seq},
                {1'b1, 4'd2, 1'b0, 16'd1});
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("g105_rec2", {bus.out_valid, bus.out_lane, bus.out_last, bus.out_seq},
                {1'b1, 4'd8, 1'b1, 16'd2});
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("g105_done", 96'(bus.out_valid), 96'(0));

    // Full group with lane 4 broken: eight records, lane 4 skipped.
    applyStimulus(1'b1, 9'h1FF, 9'h010, 1'b1);
    for (int j = 0; j < 8; j++) begin
      checkOutput($sformatf("xbreak_lane%0d", j), 96'(bus.out_lane), 96'(lanes8[j]));
      applyStimulus(1'b0, '0, '0, 1'b1);
    end
    checkOutput("xbreak_done", 96'(bus.out_valid), 96'(0));

    // Fill the FIFO with the consumer stalled, then drop a fifth group.
    for (int j = 0; j < DEPTH; j++)
      applyStimulus(1'b1, RET_LANES'(($urandom % 511) + 1), '0, 1'b0);
    checkOutput("full_stall", 96'(bus.retire_stall), 96'(1));
    checkOutput("full_no_overflow", 96'(bus.overflow), 96'(0));
    applyStimulus(1'b1, 9'h0FF, '0, 1'b0);
    checkOutput("drop_overflow", 96'(bus.overflow), 96'(1));
    for (int j = 0; j < 40; j++) applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("drain_empty", 96'(bus.out_valid), 96'(0));

    // Consumer stalls mid-group.
    applyStimulus(1'b1, 9'h0F0, '0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0);
    for (int j = 0; j < 5; j++) applyStimulus(1'b0, '0, '0, 1'b1);

    // Random traffic with random backpressure and breaks.
    for (int j = 0; j < 1500; j++)
      applyStimulus(($urandom % 4) != 0, RET_LANES'($urandom),
                    (($urandom % 3) == 0) ? RET_LANES'($urandom) : '0,
                    ($urandom % 10) < 7);
    for (int j = 0; j < 40; j++) applyStimulus(1'b0, '0, '0, 1'b1);

    // Reset while a group is mid-drain.
    applyStimulus(1'b1, 9'h1FF, '0, 1'b1);
    applyStimulus(1'b1, 9'h1FF, '0, 1'b1);
    doReset();
    checkOutput("post_rst_valid", 96'(bus.out_valid), 96'(0));
    checkOutput("post_rst_seq", 96'(bus.out_seq), 96'(0));

    // Watchdog: idle since reset release.
    for (int i = 1; i <= HANG_LIMIT; i++) begin
      applyStimulus(1'b0, '0, '0, 1'b1);
      if (i == HANG_LIMIT - 1) checkOutput("hang_before_limit", 96'(bus.hang), 96'(0));
      if (i == HANG_LIMIT)     checkOutput("hang_at_limit", 96'(bus.hang), 96'(1));
    end
    applyStimulus(1'b1, 9'h003, '0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("hang_sticky", 96'(bus.hang), 96'(1));

    // Stream records until out_seq sits at 0xFFFF, then wrap and reset.
    reached = 0;
    for (int j = 0; j < 70000 && !reached; j++) begin
      if (acceptedTotal == 65535) reached = 1;
      else applyStimulus(1'b1, 9'h1FF, '0, 1'b1);
    end
    if (!reached) begin
      nFail++;
      $display("[TB] FAIL stream_timeout: got %0d records expected 65535", acceptedTotal);
    end
    applyStimulus(1'b0, '0, '0, 1'b0);
    checkOutput("seq_ffff", 96'(bus.out_seq), 96'(16'hFFFF));
    checkOutput("valid_before_wrap", 96'(bus.out_valid), 96'(1));
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("seq_wrap", 96'(bus.out_seq), 96'(0));
    applyStimulus(1'b0, '0, '0, 1'b0);
    doReset();
    checkOutput("final_rst_valid", 96'(bus.out_valid), 96'(0));
    checkOutput("final_rst_seq", 96'(bus.out_seq), 96'(0));
    for (int j = 0; j < 4; j++) applyStimulus(1'b0, '0, '0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/retire_trace_writer.md
RETIRE_TRACE_WRITER -- requirements
Module: retire_trace_writer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, group FIFO entries (power of 2, at least 2).
REQ-002 SHALL have parameter HANG_LIMIT, default 2000, no-push cycle count that raises hang.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 retM_retire  input  1  backend retire strobe for this cycle.
REQ-006 retM_xbreak  input  9  per-lane break; a lane with break set does not retire.
REQ-007 ret_en  input  9  per-lane retire enable (retireN_enG).
REQ-008 ret_rT  input  9x6  per-lane destination register.
REQ-009 ret_data  input  9x65  per-lane result data.
REQ-010 retire_stall  output  1  group FIFO full; backend holds its retire group.
REQ-011 out_valid  output  1  trace record valid.
REQ-012 out_ready  input  1  consumer accepts record.
REQ-013 out_rT  output  6  record destination register.
REQ-014 out_data  output  65  record data.
REQ-015 out_lane  output  4  source lane index, 0..8.
REQ-016 out_last  output  1  record is the last one of its retire group.
REQ-017 out_seq  output  16  record sequence number.
REQ-018 overflow  output  1  sticky; a group was dropped.
REQ-019 hang  output  1  sticky; no group pushed for HANG_LIMIT cycles.

Function
REQ-020 Effective mask SHALL be ret_en & ~retM_xbreak & {9{retM_retire}}.
REQ-021 A group with a nonzero mask SHALL push {mask, 9 rT, 9 data} into the FIFO when not full; a zero mask SHALL never push.
REQ-022 retire_stall SHALL equal FIFO full, combinational from registered state; a same-cycle pop SHALL NOT permit a push into a full FIFO.
REQ-023 A nonzero group arriving while full SHALL be dropped and SHALL set overflow.
REQ-024 A group pushed in cycle N SHALL first appear on out_valid in cycle N+1; there is no bypass.
REQ-025 The serializer SHALL present the lowest set bit of the head group's remaining mask; out_rT, out_data and out_lane SHALL come from that lane.
REQ-026 On out_valid & out_ready the presented bit SHALL clear; out_last SHALL be 1 when it is the only remaining bit, and that handshake SHALL pop the head.
REQ-027 With out_ready held high, a group of k lanes SHALL drain in exactly k cycles and the next group SHALL follow with no bubble.
REQ-028 Outputs SHALL hold stable while out_valid & ~out_ready.
REQ-029 out_seq SHALL increment by 1 per accepted record and wrap from 0xFFFF to 0.
REQ-030 The hang counter SHALL clear on every push, otherwise increment and saturate at HANG_LIMIT; hang SHALL set when the count reaches HANG_LIMIT.
REQ-031 Pointers SHALL wrap modulo DEPTH; full/empty SHALL be resolved with an extra pointer bit.

Reset
REQ-032 On rst, FIFO pointers, remaining mask, out_seq and the hang counter SHALL clear to 0, and overflow and hang SHALL clear to 0.
REQ-033 During and after rst, out_valid=0, out_last=0, out_lane=0, out_rT=0, out_data=0 and retire_stall=0.
REQ-034 A group held in the FIFO when rst is asserted mid-drain SHALL be discarded, with no partial record afterwards.

Structure
REQ-035 The package retire_trace_pkg SHALL hold: RET_LANES=9, RT_W=6, DATA_W=65, SEQ_W=16, and the lane record and group struct typedefs.
REQ-036 The FIFO SHALL be a sub-module retire_grp_fifo (push/pop/full/empty, DEPTH entries); serializer, sequence and watchdog logic SHALL be in the top.

Verification
REQ-037 Scenario: retire=1, ret_en=0x105, xbreak=0, out_ready=1 -> records lane 0, 2, 8 on cycles N+1..N+3 with seq 0, 1, 2; out_last only on lane 8.
REQ-038 Scenario: ret_en=0x1FF, xbreak=0x010 -> 8 records with lanes 0-3 and 5-8; lane 4 is absent.
REQ-039 Scenario: out_ready=0, push 4 groups -> retire_stall=1; a 5th group sets overflow=1; raise out_ready -> 4 groups drain intact.
REQ-040 Scenario: out_ready toggles 1,0,1 mid-group -> no record lost or duplicated, and fields stay stable while stalled.
REQ-041 Scenario: no push for 2000 cycles -> hang=1 on the cycle the count hits 2000; a later push leaves hang=1.
REQ-042 Scenario: rst asserted with 2 groups queued and out_seq=0xFFFF -> out_valid=0 next cycle, seq=0; 65536 accepted records -> seq wraps to 0.
